mcu_bus_master: RTL and testbench

//  Initiator end of the MCU<->FPGA parallel register bus (5-bit address, 8-bit bidirectional data,

---
 rtl/mcu_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_mcu_bus_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_master.sv
// Initiator side of the MCU<->FPGA parallel register bus. Accepts one
// read/write command at a time on a valid/ready port and runs one strobed bus
// transaction per command. The responder answers with a one-cycle fpga_ack
// pulse. The block returns either read data or an error (bad address or ack
// timeout) as a one-cycle response pulse.
module mcu_bus_master #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int NUM_REGS     = 17,
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int TURNAROUND   = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic              CLK50,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mcu_mstr,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  input  logic              fpga_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_ERR
  } state_t;

  localparam logic [7:0]    SETUP_LAST   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]    TURN_LAST    = 8'(TURNAROUND - 1);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0]    TIMEOUT_MAX  = 8'(TIMEOUT);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  state_t                   state_q;
  logic                     cmd_ready_q;
  logic                     rsp_valid_q;
  logic [DATA_W-1:0]        rsp_rdata_q;
  logic                     rsp_err_q;
  logic                     mstr_q;
  logic                     we_q;
  logic                     data_oe_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [7:0]               cnt_q;
  logic [7:0]               timer_q;
  logic [SYNC_STAGES-1:0]   ack_sync_q;
  logic                     ack_s_d_q;

  logic ack_s;
  logic ack_rise;
  logic addr_bad;

  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign ack_rise = ack_s & ~ack_s_d_q;
  assign addr_bad = ({1'b0, cmd_addr} >= ADDR_LIMIT);

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign mcu_mstr     = mstr_q;
  assign write_enable = we_q;
  assign address      = addr_q;
  // The bus is only ever driven from a flop, so it can never glitch onto the pins.
  assign data         = data_oe_q ? wdata_q : {DATA_W{1'bz}};

  // Synchronise the asynchronous ack and keep one delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its inputs from before the clock edge regardless of statement order.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
      ack_s_d_q  <= 1'b0;
    end else begin
      ack_sync_q[0] <= fpga_ack;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
      ack_s_d_q <= ack_s;
    end
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mstr_q      <= 1'b0;
      we_q        <= 1'b0;
      data_oe_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            if (addr_bad) begin
              // Out-of-range address: answer immediately, the bus stays quiet.
              state_q     <= S_ERR;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q   <= S_SETUP;
              addr_q    <= cmd_addr;
              we_q      <= cmd_write;
              data_oe_q <= cmd_write;
              wdata_q   <= cmd_wdata;
            end
          end
        end

        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q <= S_STROBE;
            mstr_q  <= 1'b1;
            timer_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_STROBE: begin
          if (ack_rise) begin
            state_q     <= S_RELEASE;
            mstr_q      <= 1'b0;
            we_q        <= 1'b0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : data;
            cnt_q       <= '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_q     <= S_ERR;
            mstr_q      <= 1'b0;
            we_q        <= 1'b0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
          end else if (timer_q != TIMEOUT_MAX) begin
            timer_q <= timer_q + 8'd1;
          end
        end

        // Turnaround: wait for the responder to drop ack and the gap to expire.
        S_RELEASE, S_ERR: begin
          if ((cnt_q >= TURN_LAST) && !ack_s) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
          end else if (cnt_q < TURN_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_bus_master.sv
// Directed and randomized bench for mcu_bus_master with a behavioural
// register-file responder and a register-array reference model.
module tb_mcu_bus_master;

  localparam int NUM_REGS = 17;
  localparam int TIMEOUT  = 255;

  logic       CLK50;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mcu_mstr;
  logic       write_enable;
  logic [4:0] address;
  wire  [7:0] data;
  logic       fpga_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rsp_cyc = 0;

  // Responder register file and the bench's independent reference copy.
  logic [7:0] resp_mem  [32];
  logic [7:0] model_mem [32];
  bit resp_mute = 0;
  bit resp_seen = 0;
  bit resp_done = 0;

  mcu_bus_master dut (
    .CLK50        (CLK50),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mcu_mstr     (mcu_mstr),
    .write_enable (write_enable),
    .address      (address),
    .data         (data),
    .fpga_ack     (fpga_ack)
  );

  initial begin
    CLK50 = 1'b0;
    forever #10 CLK50 = ~CLK50;
  end

  always @(posedge CLK50) cyc <= cyc + 1;

  // Responder drives read data while strobed for a read.
  assign data = (mcu_mstr && !write_enable) ? resp_mem[address] : 8'bz;

  // Responder: one cycle after seeing the strobe, pulse ack once (and store writes).
  always @(negedge CLK50) begin
    if (!mcu_mstr) begin
      resp_seen = 0;
      resp_done = 0;
      fpga_ack  = 1'b0;
    end else if (!resp_seen) begin
      resp_seen = 1;
    end else if (!resp_done && !resp_mute) begin
      fpga_ack  = 1'b1;
      resp_done = 1;
      if (write_enable) resp_mem[address] = data;
    end else begin
      fpga_ack = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain register-file semantics.
  function automatic void model_cmd(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                                    output logic [7:0] rd, output logic er);
    if (int'(a) >= NUM_REGS) begin
      er = 1'b1; rd = 8'h00;
    end else if (wr) begin
      model_mem[a] = wd; er = 1'b0; rd = 8'h00;
    end else begin
      er = 1'b0; rd = model_mem[a];
    end
  endfunction

  // Issue one command (called at a negedge) and follow it to its response.
  task automatic run_cmd(input logic wr, input logic [4:0] a, input logic [7:0] wd, input bit keep,
                         input logic [7:0] exp_rd, input logic exp_err,
                         output int t_mstr, output int t_rsp, output int pulses, output int gap);
    int   w;
    int   n;
    logic prev;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge CLK50);
      w++;
    end
    check("ready_wait", 32'(w < 50), 1);
    gap = cyc - last_rsp_cyc;
    @(negedge CLK50);
    if (!keep) cmd_valid = 1'b0;
    n = 1; prev = 1'b0; t_mstr = -1; pulses = 0;
    while (!rsp_valid && n < 400) begin
      if (mcu_mstr && !prev) begin
        pulses++;
        if (t_mstr < 0) t_mstr = n;
      end
      prev = mcu_mstr;
      check("oe_only_on_write", 32'(dut.data_oe_q && !(wr && write_enable)), 0);
      if (mcu_mstr) check("bus_addr", address, a);
      if (mcu_mstr && wr) check("bus_wdata", data, wd);
      @(negedge CLK50);
      n++;
    end
    check("rsp_seen", rsp_valid, 1);
    t_rsp = n;
    last_rsp_cyc = cyc;
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, exp_err);
    check("rel_mstr", mcu_mstr, 0);
    check("rel_we", write_enable, 0);
    check("rel_oe", dut.data_oe_q, 0);
    @(negedge CLK50);
    check("rsp_one_cycle", rsp_valid, 0);
    check("rsp_rdata_hold", rsp_rdata, exp_rd);
    check("rsp_err_hold", rsp_err, exp_err);
  endtask

  // Model the command, run it, and check the expected bus timing.
  task automatic do_txn(input string tag, input logic wr, input logic [4:0] a, input logic [7:0] wd,
                        input bit keep, input bit chk_gap);
    logic [7:0] erd;
    logic       eer;
    int tm, tr, p, g;
    model_cmd(wr, a, wd, erd, eer);
    run_cmd(wr, a, wd, keep, erd, eer, tm, tr, p, g);
    if (int'(a) >= NUM_REGS) begin
      check({tag, "_no_strobe"}, p, 0);
      check({tag, "_err_latency"}, tr, 1);
    end else begin
      check({tag, "_one_strobe"}, p, 1);
      check({tag, "_strobe_latency"}, tm, 2);
      check({tag, "_rsp_latency"}, tr, 6);
    end
    if (chk_gap) check({tag, "_turnaround"}, 32'(g >= 2), 1);
  endtask

  initial begin
    int tm, tr, p, g;
    logic [4:0] ra;
    for (int i = 0; i < 32; i++) begin
      resp_mem[i]  = 8'($urandom);
      model_mem[i] = resp_mem[i];
    end
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; fpga_ack = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK50);
    check("rst_ready", cmd_ready, 0);
    check("rst_mstr", mcu_mstr, 0);
    check("rst_we", write_enable, 0);
    check("rst_addr", address, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_oe", dut.data_oe_q, 0);
    rst_n = 1'b1;
    @(negedge CLK50);
    check("ready_after_rst", cmd_ready, 1);

    // T1: write 0xA5 to register 3
    do_txn("t1", 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0);
    check("t1_reg3", resp_mem[3], 8'hA5);

    // T2: read the top register
    resp_mem[16] = 8'h3C; model_mem[16] = 8'h3C;
    do_txn("t2", 1'b0, 5'd16, 8'h00, 1'b0, 1'b0);

    // T3: out-of-range address
    do_txn("t3", 1'b1, 5'd17, 8'h55, 1'b0, 1'b0);

    // T4: muted responder -> timeout
    resp_mute = 1;
    run_cmd(1'b0, 5'd2, 8'h00, 1'b0, 8'h00, 1'b1, tm, tr, p, g);
    check("t4_timeout_cycles", tr - tm, TIMEOUT);
    check("t4_one_strobe", p, 1);
    resp_mute = 0;
    repeat (4) @(negedge CLK50);

    // T5: back-to-back alternating write/read with cmd_valid held
    for (int i = 0; i < 10; i++) begin
      ra = 5'($urandom_range(0, NUM_REGS - 1));
      do_txn("t5", (i % 2) == 0, ra, 8'($urandom), 1'b1, i > 0);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge CLK50);

    // T6: reset during strobe of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd5; cmd_wdata = ~model_mem[5];
    begin
      int w = 0;
      while (!cmd_ready && w < 50) begin @(negedge CLK50); w++; end
      check("t6_ready_wait", 32'(w < 50), 1);
    end
    @(negedge CLK50);
    cmd_valid = 1'b0;
    @(negedge CLK50);
    check("t6_strobe_up", mcu_mstr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_mstr_dropped", mcu_mstr, 0);
    check("t6_oe_dropped", dut.data_oe_q, 0);
    check("t6_we_dropped", write_enable, 0);
    repeat (2) begin
      @(negedge CLK50);
      check("t6_no_rsp", rsp_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge CLK50);
    check("t6_ready_again", cmd_ready, 1);
    check("t6_no_rsp_after", rsp_valid, 0);
    do_txn("t6_readback", 1'b0, 5'd5, 8'h00, 1'b0, 1'b0);

    // Randomized mix over the full address space
    for (int i = 0; i < 40; i++) begin
      do_txn("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), 1'b0, 1'b0);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      check("final_regfile", resp_mem[i], model_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
